// File: rtl/boot_seq_ctrl.sv
// Boot and run sequencer for the single-cycle MIPS core.
// Loads a length-prefixed byte stream into instruction memory in big-endian order,
// holds the core in reset for a fixed time, lets it run, then stops it and reports why.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_LEN_HI | waiting for the high byte of the load length
// S_LEN_LO | waiting for the low byte of the load length
// S_LOAD   | writing stream bytes to consecutive instruction memory addresses
// S_HOLD   | load finished, core still held in reset for HOLD_CYC cycles
// S_RUN    | core running, NOP and cycle counters active
// S_DONE   | core frozen, halted/timed_out report the cause; left only by rst
module boot_seq_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int HOLD_CYC  = 10,
  parameter int NOP_LIMIT = 9,
  parameter int TIMEOUT   = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [31:0]       inst,
  output logic              core_rst_n,
  output logic              core_en,
  output logic              halted,
  output logic              timed_out,
  output logic              ovf,
  output logic              done
);

  localparam int CYC_W  = $clog2(TIMEOUT + 1);
  localparam int NOP_W  = $clog2(NOP_LIMIT + 1);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  // One extra bit so a full 2^16-byte memory still compares correctly.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       byte_cnt_q, byte_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [NOP_W-1:0]  nop_cnt_q, nop_cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              core_en_q, core_en_d;
  logic              halted_q, halted_d;
  logic              timed_out_q, timed_out_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              xfer;
  logic [15:0]       len_full;

  // Stream handshake: only the length and load states accept bytes, never during rst.
  always_comb begin
    in_ready = !rst && (state_q == S_LEN_HI || state_q == S_LEN_LO || state_q == S_LOAD);
  end

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    cyc_cnt_d    = cyc_cnt_q;
    nop_cnt_d    = nop_cnt_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_rst_n_d = core_rst_n_q;
    core_en_d    = core_en_q;
    halted_d     = halted_q;
    timed_out_d  = timed_out_q;
    ovf_d        = ovf_q;
    done_d       = done_q;
    xfer         = in_valid && in_ready;
    len_full     = {len_q[15:8], in_data};

    case (state_q)
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = in_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_full;
          if (len_full == 16'd0) begin
            state_d    = S_HOLD;
            hold_cnt_d = HOLD_W'(HOLD_CYC - 1);
          end else begin
            state_d    = S_LOAD;
            byte_cnt_d = 16'd0;
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          // Bytes past the end of memory are still consumed so the stream stays in sync.
          if ({1'b0, byte_cnt_q} < DEPTH) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = byte_cnt_q[ADDR_W-1:0];
            mem_wdata_d = in_data;
          end else begin
            ovf_d = 1'b1;
          end
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (byte_cnt_q == len_q - 16'd1) begin
            state_d    = S_HOLD;
            hold_cnt_d = HOLD_W'(HOLD_CYC - 1);
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d      = S_RUN;
          core_rst_n_d = 1'b1;
          core_en_d    = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      S_RUN: begin
        cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        nop_cnt_d = nop_cnt_q + NOP_W'(inst == 32'h0);
        // The NOP halt is checked first so it wins when both limits land together.
        if (nop_cnt_d == NOP_W'(NOP_LIMIT)) begin
          state_d   = S_DONE;
          halted_d  = 1'b1;
          core_en_d = 1'b0;
          done_d    = 1'b1;
        end else if (cyc_cnt_d == CYC_W'(TIMEOUT)) begin
          state_d     = S_DONE;
          timed_out_d = 1'b1;
          core_en_d   = 1'b0;
          done_d      = 1'b1;
        end
      end
      S_DONE: begin
        // Core stays out of reset but frozen so its state can be inspected.
      end
      default: state_d = S_LEN_HI;
    endcase
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LEN_HI;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      cyc_cnt_q    <= '0;
      nop_cnt_q    <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_rst_n_q <= 1'b0;
      core_en_q    <= 1'b0;
      halted_q     <= 1'b0;
      timed_out_q  <= 1'b0;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      cyc_cnt_q    <= cyc_cnt_d;
      nop_cnt_q    <= nop_cnt_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      core_en_q    <= core_en_d;
      halted_q     <= halted_d;
      timed_out_q  <= timed_out_d;
      ovf_q        <= ovf_d;
      done_q       <= done_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign core_en    = core_en_q;
  assign halted     = halted_q;
  assign timed_out  = timed_out_q;
  assign ovf        = ovf_q;
  assign done       = done_q;

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Self-checking bench for boot_seq_ctrl: random streams and instruction traces
// compared against a behavioural model of load, hold and run outcomes.
module tb_boot_seq_ctrl;

  localparam int ADDR_W    = 10;
  localparam int HOLD_CYC  = 10;
  localparam int NOP_LIMIT = 9;
  localparam int TIMEOUT   = 100;
  localparam int DEPTH     = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [31:0]       inst;
  logic              core_rst_n;
  logic              core_en;
  logic              halted;
  logic              timed_out;
  logic              ovf;
  logic              done;

  boot_seq_ctrl #(
    .ADDR_W(ADDR_W), .HOLD_CYC(HOLD_CYC), .NOP_LIMIT(NOP_LIMIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .inst(inst),
    .core_rst_n(core_rst_n), .core_en(core_en), .halted(halted), .timed_out(timed_out),
    .ovf(ovf), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_addr[$];
  logic [7:0]  wr_data[$];
  logic [7:0]  payload[$];
  logic [31:0] run_seq[TIMEOUT];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic collect();
    if (mem_we === 1'b1) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(mem_wdata);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_mem_we", mem_we, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_wdata", mem_wdata, 0);
    check_val("rst_core_rst_n", core_rst_n, 0);
    check_val("rst_core_en", core_en, 0);
    check_val("rst_flags", {halted, timed_out, ovf, done}, 0);
  endtask

  // mode 0: random valid gaps; mode 1: valid every other cycle. Stops after stop_at transfers.
  task automatic drive_stream(input logic [7:0] s[$], input int mode, input int stop_at,
                              output int sent);
    int cyc;
    int target;
    logic v;
    logic tog;
    cyc = 0;
    tog = 1'b0;
    sent = 0;
    target = (stop_at < 0) ? s.size() : stop_at;
    while (sent < target && cyc < 5000) begin
      @(negedge clk);
      collect();
      cyc++;
      v = (mode == 1) ? tog : ($urandom_range(0, 3) != 0);
      tog = ~tog;
      in_valid = v;
      in_data = v ? s[sent] : 8'($urandom);
      if (v && in_ready) sent++;
    end
    check_val("stream_sent", sent, target);
  endtask

  // Run outcome derived directly from the counting rules.
  task automatic model_run(output int n, output bit h, output bit t);
    int nops;
    nops = 0;
    n = 0;
    h = 0;
    t = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      if (run_seq[k-1] == 32'h0) nops++;
      if (nops == NOP_LIMIT) begin
        n = k; h = 1; return;
      end
      if (k == TIMEOUT) begin
        n = k; t = 1; return;
      end
    end
  endtask

  // inst_kind: 0 all NOP, 1 constant non-NOP, 2 91 non-NOP then NOPs, 3 random mix.
  task automatic run_case(input int len, input int mode, input int inst_kind);
    logic [7:0] s[$];
    int sent, hold, n, exp_wr, exp_n, en_gap;
    bit exp_h, exp_t;
    do_reset();
    wr_addr.delete();
    wr_data.delete();
    s.push_back(8'(len >> 8));
    s.push_back(8'(len));
    for (int k = 0; k < len; k++) s.push_back(payload[k]);
    drive_stream(s, mode, -1, sent);
    hold = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      collect();
      in_valid = 1'b0;
      if (core_rst_n !== 1'b0) break;
      hold++;
    end
    check_val("hold_cycles", hold, HOLD_CYC);
    exp_wr = (len < DEPTH) ? len : DEPTH;
    check_val("wr_count", wr_addr.size(), exp_wr);
    for (int k = 0; k < wr_addr.size() && k < exp_wr; k++) begin
      check_val("wr_addr", wr_addr[k], k);
      check_val("wr_data", wr_data[k], payload[k]);
    end
    check_val("ovf", ovf, (len > DEPTH) ? 1 : 0);
    check_val("run_start_en", {core_rst_n, core_en}, 2'b11);

    for (int k = 0; k < TIMEOUT; k++) begin
      case (inst_kind)
        0: run_seq[k] = 32'h0;
        1: run_seq[k] = 32'h20080005;
        2: run_seq[k] = (k < 91) ? ($urandom | 32'h1) : 32'h0;
        default: run_seq[k] = ($urandom_range(0, 11) == 0) ? 32'h0 : ($urandom | 32'h100);
      endcase
    end
    model_run(exp_n, exp_h, exp_t);
    n = 0;
    en_gap = 0;
    while (done !== 1'b1 && n < TIMEOUT + 5) begin
      if (core_en !== 1'b1) en_gap++;
      inst = (n < TIMEOUT) ? run_seq[n] : 32'h0;
      n++;
      @(negedge clk);
      collect();
    end
    check_val("run_cycles", n, exp_n);
    check_val("run_en_gap", en_gap, 0);
    check_val("halted", halted, exp_h);
    check_val("timed_out", timed_out, exp_t);
    check_val("done_core", {core_rst_n, core_en, in_ready}, 3'b100);

    // Stream bytes offered in DONE must be ignored.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data = 8'($urandom);
      @(negedge clk);
      collect();
    end
    in_valid = 1'b0;
    check_val("done_sticky", {done, halted, timed_out}, {1'b1, exp_h, exp_t});
    check_val("done_no_write", wr_addr.size(), exp_wr);
  endtask

  task automatic mid_load_reset();
    logic [7:0] s[$];
    int sent;
    do_reset();
    wr_addr.delete();
    wr_data.delete();
    payload.delete();
    for (int k = 0; k < 20; k++) payload.push_back(8'($urandom));
    s.push_back(8'd0);
    s.push_back(8'd20);
    for (int k = 0; k < 20; k++) s.push_back(payload[k]);
    drive_stream(s, 1, 12, sent);
    @(negedge clk);
    collect();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = payload[10];
    #1;
    check_val("rst_hi_in_ready", in_ready, 0);
    @(negedge clk);
    collect();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check_val("mid_rst_mem_we", mem_we, 0);
    check_val("mid_rst_in_ready", in_ready, 1);
    check_val("mid_rst_core_rst_n", core_rst_n, 0);
    check_val("mid_rst_flags", {core_en, done, ovf}, 0);
    check_val("mid_wr_count", wr_addr.size(), 10);
    for (int k = 0; k < wr_addr.size() && k < 10; k++) begin
      check_val("mid_wr_addr", wr_addr[k], k);
      check_val("mid_wr_data", wr_data[k], payload[k]);
    end
  endtask

  initial begin
    int len;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h0;
    inst = 32'h0;

    payload = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    run_case(8, 0, 0);
    run_case(8, 1, 1);

    payload.delete();
    for (int k = 0; k < 12; k++) payload.push_back(8'($urandom));
    run_case(12, 0, 2);

    payload.delete();
    for (int k = 0; k < 1025; k++) payload.push_back(8'($urandom));
    run_case(1025, 0, 3);

    run_case(0, 0, 3);

    mid_load_reset();

    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 40);
      payload.delete();
      for (int k = 0; k < len; k++) payload.push_back(8'($urandom));
      run_case(len, $urandom_range(0, 1), 3);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
